// File: rtl/fifo_gather.sv
// Purpose: serial-in/parallel-out gather; DEPTH words of BITS collect into one block, word 0 first.
// Latency: out_valid rises the cycle after the edge that accepts the block's last word.
// Backpressure: in_ready drops only when the next word completes a block and the held block is not draining.
module fifo_gather #(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BITS-1:0]          d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITS-1:0]          q [DEPTH-1:0],
  output logic [$clog2(DEPTH)-1:0] cnt
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  // Partial block; the final element is never stored here because the
  // completing word goes straight from d into q.
  logic [BITS-1:0] col [DEPTH-1:0];

  logic last;
  logic accept;
  logic complete;

  // Handshake decode: stall only when a completion would overwrite an unconsumed block.
  always_comb begin
    last     = (cnt == LAST);
    in_ready = !(last && out_valid && !out_ready);
    accept   = in_valid && in_ready && !clr;
    complete = accept && last;
  end

  // Write index: clear wins over accept; wraps to 0 only through completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (accept) begin
      if (last) cnt <= '0;
      else      cnt <= cnt + CW'(1);
    end
  end

  // Collect buffer: store each non-final accepted word at the write index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) col[i] <= '0;
    end else if (accept && !last) begin
      col[cnt] <= d;
    end
  end

  // Holding register: load on completion (even while draining), else clear valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      out_valid <= 1'b0;
    end else if (complete) begin
      for (int i = 0; i < DEPTH - 1; i++) q[i] <= col[i];
      q[DEPTH-1] <= d;
      out_valid  <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_gather.sv
// Directed bench for fifo_gather (DEPTH=8, BITS=64).
// Inputs change 1ns after each rising edge; outputs are sampled there too.
// Expected values are hand-derived constants and simple index arithmetic.
module tb_fifo_gather;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] d;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] q [7:0];
  logic [2:0]  cnt;

  int total = 0;
  int bad   = 0;

  fifo_gather #(.DEPTH(8), .BITS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .cnt       (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Check that q holds base, base+1, ... base+7.
  task automatic chkq(input string tag, input logic [63:0] base);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_q%0d", tag, i), q[i], base + 64'(i));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one word for exactly one edge; consecutive calls stream back-to-back.
  task automatic send(input logic [63:0] w);
    in_valid = 1'b1;
    d        = w;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    d         = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_ovld", 64'(out_valid), 64'd0);
    chk("rst_irdy", 64'(in_ready), 64'd1);
    chk("rst_q0", q[0], 64'd0);
    chk("rst_q7", q[7], 64'd0);
    rst_n = 1'b1;
    tick();

    // Fill with drain
    out_ready = 1'b1;
    for (int w = 1; w <= 8; w++) begin
      send(64'(w));
      if (w == 3) chk("fill_cnt3", 64'(cnt), 64'd3);
    end
    chk("fill_ovld", 64'(out_valid), 64'd1);
    chk("fill_cnt", 64'(cnt), 64'd0);
    chkq("fill", 64'd1);
    tick();
    chk("fill_drained", 64'(out_valid), 64'd0);
    chk("fill_qhold", q[0], 64'd1);

    // Backpressure
    out_ready = 1'b0;
    for (int w = 1; w <= 8; w++) send(64'(w));
    chk("bp_ovld", 64'(out_valid), 64'd1);
    chk("bp_q0", q[0], 64'd1);
    chk("bp_q7", q[7], 64'd8);
    for (int w = 9; w <= 15; w++) send(64'(w));
    chk("bp_cnt7", 64'(cnt), 64'd7);
    chk("bp_hold_q0", q[0], 64'd1);
    in_valid = 1'b1;
    d        = 64'd16;
    #1;
    chk("bp_irdy_low", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) tick();
    chk("bp_stall_cnt", 64'(cnt), 64'd7);
    chk("bp_stall_ovld", 64'(out_valid), 64'd1);
    chk("bp_stall_q7", q[7], 64'd8);
    chk("bp_stall_irdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_irdy_pulse", 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_swap_ovld", 64'(out_valid), 64'd1);
    chk("bp_swap_cnt", 64'(cnt), 64'd0);
    chkq("bp_swap", 64'd9);
    out_ready = 1'b1;
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Gapped input: accepted words on even steps only
    for (int i = 0; i < 15; i++) begin
      in_valid = (i % 2 == 0);
      d        = (i % 2 == 0) ? 64'(32'hA0 + i / 2) : 64'hDEAD;
      tick();
      chk($sformatf("gap_cnt%0d", i), 64'(cnt), 64'((i / 2 + 1) % 8));
    end
    in_valid = 1'b0;
    chk("gap_ovld", 64'(out_valid), 64'd1);
    chkq("gap", 64'hA0);
    tick();

    // Clear mid-fill with a pending block
    out_ready = 1'b0;
    for (int w = 0; w < 8; w++) send(64'(32'h50 + w));
    send(64'h01);
    send(64'h02);
    send(64'h03);
    chk("clr_pre_cnt", 64'(cnt), 64'd3);
    clr      = 1'b1;
    in_valid = 1'b1;
    d        = 64'hFF;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_cnt", 64'(cnt), 64'd0);
    chk("clr_ovld", 64'(out_valid), 64'd1);
    chkq("clr_pending", 64'h50);
    out_ready = 1'b1;
    tick();
    chk("clr_drained", 64'(out_valid), 64'd0);
    for (int w = 0; w < 8; w++) send(64'(32'h10 + w));
    chk("clr_new_ovld", 64'(out_valid), 64'd1);
    chkq("clr_new", 64'h10);
    tick();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int w = 0; w < 8; w++) send(64'(32'h60 + w));
    for (int w = 0; w < 5; w++) send(64'(32'h70 + w));
    chk("ar_pre_cnt", 64'(cnt), 64'd5);
    chk("ar_pre_ovld", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ovld", 64'(out_valid), 64'd0);
    chk("ar_cnt", 64'(cnt), 64'd0);
    chk("ar_irdy", 64'(in_ready), 64'd1);
    chk("ar_q0", q[0], 64'd0);
    chk("ar_q7", q[7], 64'd0);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int w = 0; w < 8; w++) send(64'(32'h80 + w));
    chk("ar_refill_ovld", 64'(out_valid), 64'd1);
    chkq("ar_refill", 64'h80);

    // Completion on the same edge as drain
    out_ready = 1'b0;
    for (int w = 0; w < 7; w++) send(64'(32'h90 + w));
    chk("sim_cnt7", 64'(cnt), 64'd7);
    chk("sim_hold_q0", q[0], 64'h80);
    in_valid  = 1'b1;
    d         = 64'h97;
    out_ready = 1'b1;
    #1;
    chk("sim_irdy", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("sim_ovld", 64'(out_valid), 64'd1);
    chk("sim_cnt", 64'(cnt), 64'd0);
    chkq("sim", 64'h90);
    tick();
    chk("sim_drained", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
